nash_decipher_rx: RTL
=====================

Name: nash_decipher_rx

Overview:
Receive-side bit-serial decryptor for the Nash cipher datapath.
- Consumes the cipher bit stream from the encrypt stage through a valid/ready handshake.
- Regenerates the self-synchronising keystream from the shared key and the cipher history, and recovers each plaintext bit.
- Packs recovered bits LSB-first into bytes on a valid/ready output, and sits between the channel and the byte-oriented sink.

Parameters:
KEY_W, 8, key and keystream-state width in bits.
FRAME_BITS, 0, resync interval in accepted cipher bits; 0 disables resync.

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous reset, active-high
key_data  in  KEY_W  key value, sampled only when key_load=1
key_load  in  1  one-cycle strobe: latch key and restart the cipher
in_bit  in  1  cipher bit
in_valid  in  1  in_bit is valid
in_ready  out  1  block accepts in_bit this cycle
out_byte  out  8  recovered plaintext byte; bit0 is the first bit received
out_valid  out  1  out_byte holds an unconsumed byte
out_ready  in  1  sink takes out_byte
frame_sync  out  1  one-cycle pulse when a frame resync occurs

Behaviour:
- Reset values: K=0, S=0, bit_cnt=0, frame_cnt=0, out_byte=0x00, out_valid=0, frame_sync=0, state=IDLE.
  - in_ready=0 during reset and in IDLE.
- States:
  - IDLE (no key loaded): key_load -> RUN.
  - RUN: stays in RUN.
  - key_load in RUN restarts the cipher and the state stays RUN.
- Key load, in any state:
  - K<=key_data, S<=key_data, bit_cnt<=0, frame_cnt<=0, out_valid<=0.
  - in_ready is forced 0 combinationally while key_load=1, so no bit is accepted in that cycle.
- Keystream and recovery:
  - ks = XOR-reduce(S & K).
  - p = in_bit ^ ks.
  - On accept, S <= {S[KEY_W-2:0], in_bit}. The cipher bit is shifted in, not the plaintext bit.
- Accept condition: in_valid & in_ready.
  - in_ready = (state==RUN) & !key_load & !(bit_cnt==7 & out_valid & !out_ready).
  - Bits 0..6 of the next byte may be accepted while the previous byte is still waiting. The block stalls only when the 8th bit would overwrite an unconsumed byte.
- Packing:
  - p is written to shift position bit_cnt.
  - On the accept with bit_cnt==7: out_byte <= {p, bits[6:0]}, out_valid <= 1 (visible the next cycle), bit_cnt <= 0.
  - Latency: out_valid rises 1 cycle after the 8th accepted bit.
- Output handshake:
  - out_valid clears on out_valid & out_ready unless a new byte completes in the same cycle, in which case out_valid stays 1 and out_byte takes the new byte.
  - out_byte is held stable while out_valid=1 and out_ready=0.
- Frame resync (FRAME_BITS>0):
  - frame_cnt counts accepted bits.
  - On the accept with frame_cnt==FRAME_BITS-1: S <= K instead of the shift, frame_cnt <= 0, frame_sync=1 on the next cycle.
  - bit_cnt is not affected, so byte alignment is independent of frame alignment.
- Wrap-around: bit_cnt is 3 bits and wraps 7->0. frame_cnt is clog2(FRAME_BITS) bits and never exceeds FRAME_BITS-1.
- Reset mid-operation: all state returns to reset values; the partial byte and any pending byte are discarded.
- Simultaneous key_load with out_ready: the pending byte is discarded and the handshake is ignored.

Decomposition:
- Package nash_cipher_pkg holds:
  - KEY_W default constant
  - function nash_ks(state, key)
  - function nash_next_state(state, cbit)
  - state enum {IDLE, RUN}
- The encrypt side imports the same package, so both directions share the keystream definition.
- One natural sub-module: nash_keystream_gen. It holds the S/K registers, load, shift and resync, and outputs ks. The byte packer and handshake logic stay in the top.

Test Plan:
1. rst=1 for 2 cycles, then key_load with key_data=0x00, then cipher bits of 0xA5 LSB-first with continuous valid -> out_byte=0xA5, out_valid=1 one cycle after the 8th bit.
2. key_load with 0x55, then 8 zero cipher bits -> ks sequence 0,0,1,0,0,0,1,0 and out_byte=0x44.
3. Backpressure: out_ready=0 with 15 bits offered -> 0x44 held stable, in_ready drops at bit 16. Raising out_ready -> both bytes delivered in order with no loss or duplication.
4. Loopback: encrypt stage with key 0x55 driven by 0xA5A5 LSB-first -> received bytes 0xA5, 0xA5.
5. FRAME_BITS=8, key 0x55, 16 zero bits -> frame_sync pulses after bits 8 and 16, and both bytes=0x44.
6. key_load mid-byte after 5 bits, or rst asserted with out_valid=1 -> out_valid=0 next cycle, the partial byte is dropped, and the next 8 zero bits with key 0x55 give 0x44.

Source files
------------

// File: rtl/nash_cipher_pkg.sv
// nash_cipher_pkg: keystream definition shared by the encrypt and decrypt directions.
package nash_cipher_pkg;
    localparam int NASH_KEY_W = 8;
    localparam int KS_MAX_W   = 64;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;
    // Callers zero-extend their state to KS_MAX_W and truncate the result back.
    function automatic logic nash_ks(input logic [KS_MAX_W-1:0] s, input logic [KS_MAX_W-1:0] k);
        return ^(s & k);
    endfunction
    function automatic logic [KS_MAX_W-1:0] nash_next_state(input logic [KS_MAX_W-1:0] s, input logic cbit);
        return {s[KS_MAX_W-2:0], cbit};
    endfunction
endpackage

// File: rtl/nash_keystream_gen.sv
// nash_keystream_gen: key/state registers, cipher-history shift and frame resync.
module nash_keystream_gen import nash_cipher_pkg::*; #(
    parameter int KEY_W      = NASH_KEY_W,
    parameter int FRAME_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_data,
    input  logic             key_load,
    input  logic             shift,
    input  logic             cbit,
    output logic             ks,
    output logic             frame_sync
);
    localparam int FC_W = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
    logic [KEY_W-1:0] k_q, k_d, s_q, s_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             sync_q, sync_d, wrap;
    always_comb begin
        wrap   = FRAME_BITS > 0 && fc_q == FC_W'(FRAME_BITS - 1);
        k_d    = key_load ? key_data : k_q;
        s_d    = key_load ? key_data : !shift ? s_q : wrap ? k_q :
                 KEY_W'(nash_next_state(KS_MAX_W'(s_q), cbit));
        fc_d   = (key_load || FRAME_BITS == 0) ? '0 : !shift ? fc_q : wrap ? '0 : fc_q + 1'b1;
        sync_d = !key_load && shift && wrap;
        ks     = nash_ks(KS_MAX_W'(s_q), KS_MAX_W'(k_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            s_q    <= '0;
            fc_q   <= '0;
            sync_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            s_q    <= s_d;
            fc_q   <= fc_d;
            sync_q <= sync_d;
        end
    end
    assign frame_sync = sync_q;
endmodule

// File: rtl/nash_decipher_rx.sv
// nash_decipher_rx: bit-serial Nash decryptor packing plaintext LSB-first into bytes.
module nash_decipher_rx import nash_cipher_pkg::*; #(
    parameter int KEY_W      = NASH_KEY_W,
    parameter int FRAME_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_data,
    input  logic             key_load,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_sync
);
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] bits_q, bits_d;
    logic [7:0] byte_q, byte_d;
    logic       ov_q, ov_d, acc, done, p, ks;
    nash_keystream_gen #(.KEY_W(KEY_W), .FRAME_BITS(FRAME_BITS)) u_ks (
        .clk(clk), .rst(rst), .key_data(key_data), .key_load(key_load),
        .shift(acc), .cbit(in_bit), .ks(ks), .frame_sync(frame_sync)
    );
    // Only the 8th bit of a byte must wait for the sink; earlier bits fill the shifter.
    always_comb begin
        in_ready = state_q == RUN && !key_load && !(cnt_q == 3'd7 && ov_q && !out_ready);
        acc      = in_valid && in_ready;
        done     = acc && cnt_q == 3'd7;
        p        = in_bit ^ ks;
        state_d  = key_load ? RUN : state_q;
        cnt_d    = key_load ? 3'd0 : acc ? cnt_q + 3'd1 : cnt_q;
        bits_d   = bits_q;
        if (acc && !done) bits_d[cnt_q] = p;
        byte_d   = done ? {p, bits_q} : byte_q;
        ov_d     = key_load ? 1'b0 : done ? 1'b1 : ov_q && !out_ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            bits_q  <= 7'd0;
            byte_q  <= 8'd0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            byte_q  <= byte_d;
            ov_q    <= ov_d;
        end
    end
    assign out_byte  = byte_q;
    assign out_valid = ov_q;
endmodule
